// File: rtl/i2f_issue_ctrl.sv
// ============================================================================
// Module      : i2f_issue_ctrl
// Description : Valid/ready front-end for a single-cycle i2f converter with
//               inexact-flag generation and an in-order tagged result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2f_issue_ctrl #(
    parameter int FPWID = 32,
    parameter int MANTW = 23,
    parameter int TAGW  = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [FPWID-1:0] req_int,
    input  logic [2:0]       req_rm,
    input  logic [TAGW-1:0]  req_tag,
    output logic             cvt_ce,
    output logic [2:0]       cvt_rm,
    output logic [FPWID-1:0] cvt_i,
    input  logic [FPWID-1:0] cvt_o,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [FPWID-1:0] rsp_f,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             rsp_inexact
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [PTRW-1:0]  r_wr_ptr;
    logic [PTRW-1:0]  r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             r_inflight;
    logic [TAGW-1:0]  r_stage_tag;
    logic             r_stage_inexact;

    logic [FPWID-1:0] r_mem_f   [DEPTH];
    logic [TAGW-1:0]  r_mem_tag [DEPTH];
    logic             r_mem_inx [DEPTH];

    logic [FPWID-1:0] w_mag;
    int               w_msb;
    logic             w_inexact;
    logic [CNTW-1:0]  w_occ;
    logic             w_accept;
    logic             w_write;
    logic             w_read;

    assign cvt_ce = 1'b1;
    assign cvt_i  = req_int;
    assign cvt_rm = req_rm;

    // Most-negative input wraps to 2^(FPWID-1), which is its true magnitude.
    assign w_mag = req_int[FPWID-1] ? (~req_int + FPWID'(1)) : req_int;

    always_comb begin
        w_msb     = 0;
        w_inexact = 1'b0;
        for (int i = 0; i < FPWID; i++) begin
            if (w_mag[i]) w_msb = i;
        end
        // Any set bit more than MANTW positions below the MSB is lost by rounding.
        for (int i = 0; i < FPWID; i++) begin
            if (w_mag[i] && ((i + MANTW) < w_msb)) w_inexact = 1'b1;
        end
    end

    // Credit counts the in-flight op so every accepted request has a FIFO slot.
    assign w_occ     = r_count + CNTW'(r_inflight);
    assign req_ready = !flush && (w_occ < CNTW'(DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_write   = r_inflight && !flush;
    assign w_read    = rsp_valid && rsp_ready && !flush;

    assign rsp_valid   = (r_count != '0);
    assign rsp_f       = r_mem_f[r_rd_ptr];
    assign rsp_tag     = r_mem_tag[r_rd_ptr];
    assign rsp_inexact = r_mem_inx[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_inflight      <= 1'b0;
            r_stage_tag     <= '0;
            r_stage_inexact <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_stage_tag     <= req_tag;
                r_stage_inexact <= w_inexact;
            end
            if (w_write) r_wr_ptr <= r_wr_ptr + PTRW'(1);
            if (w_read)  r_rd_ptr <= r_rd_ptr + PTRW'(1);
            r_count <= r_count + CNTW'(w_write) - CNTW'(w_read);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_f[i]   <= '0;
                r_mem_tag[i] <= '0;
                r_mem_inx[i] <= 1'b0;
            end
        end else if (w_write) begin
            r_mem_f[r_wr_ptr]   <= cvt_o;
            r_mem_tag[r_wr_ptr] <= r_stage_tag;
            r_mem_inx[r_wr_ptr] <= r_stage_inexact;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2f_issue_ctrl.sv
// ============================================================================
// Module      : tb_i2f_issue_ctrl
// Description : Scoreboard bench for i2f_issue_ctrl with a behavioural i2f model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2f_issue_ctrl;

    localparam int FPWID = 32;
    localparam int MANTW = 23;
    localparam int TAGW  = 4;
    localparam int DEPTH = 4;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             flush     = 1'b0;
    logic             req_valid = 1'b0;
    logic [31:0]      req_int   = '0;
    logic [2:0]       req_rm    = '0;
    logic [TAGW-1:0]  req_tag   = '0;
    logic             rsp_ready = 1'b0;
    logic [31:0]      cvt_o     = '0;
    logic             req_ready;
    logic             cvt_ce;
    logic [2:0]       cvt_rm;
    logic [31:0]      cvt_i;
    logic             rsp_valid;
    logic [31:0]      rsp_f;
    logic [TAGW-1:0]  rsp_tag;
    logic             rsp_inexact;

    i2f_issue_ctrl #(.FPWID(FPWID), .MANTW(MANTW), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_int(req_int),
        .req_rm(req_rm), .req_tag(req_tag),
        .cvt_ce(cvt_ce), .cvt_rm(cvt_rm), .cvt_i(cvt_i), .cvt_o(cvt_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_f(rsp_f),
        .rsp_tag(rsp_tag), .rsp_inexact(rsp_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     f;
        logic [TAGW-1:0] tag;
        logic            inex;
        int              acc_edge;
    } item_t;

    item_t exp_q[$];
    int    edges  = 0;
    int    passed = 0;
    int    total  = 0;

    always @(posedge clk) edges <= edges + 1;

    function automatic longint mag_of(input logic [31:0] x);
        return x[31] ? ((longint'(1) << 32) - longint'(x)) : longint'(x);
    endfunction

    // Reference single-precision conversion with the five rounding modes.
    function automatic logic [31:0] ref_i2f(input logic [31:0] x, input logic [2:0] rm);
        logic   s;
        longint mag, keep, rem, half;
        int     p, sh;
        logic   up;
        s   = x[31];
        mag = mag_of(x);
        if (mag == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 33; i++) if (mag[i]) p = i;
        if (p <= MANTW) return {s, 8'(127 + p), 23'(mag << (MANTW - p))};
        sh   = p - MANTW;
        keep = mag >> sh;
        rem  = mag & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = (rem != 0) && !s;
            3'd3:    up = (rem != 0) && s;
            3'd4:    up = (rem >= half);
            default: up = (rem > half) || ((rem == half) && keep[0]);
        endcase
        keep = keep + longint'(up);
        if (keep == (longint'(1) << (MANTW + 1))) begin
            keep = keep >> 1;
            p++;
        end
        return {s, 8'(127 + p), 23'(keep)};
    endfunction

    // Inexact iff the significant span (trailing zeros stripped) exceeds MANTW+1 bits.
    function automatic logic ref_inexact(input logic [31:0] x);
        longint mag;
        mag = mag_of(x);
        if (mag == 0) return 1'b0;
        while (mag[0] == 1'b0) mag = mag >> 1;
        return mag >= (longint'(1) << (MANTW + 1));
    endfunction

    always @(posedge clk) if (cvt_ce) cvt_o <= ref_i2f(cvt_i, cvt_rm);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        else passed++;
    endtask

    task automatic step(input logic v, input logic [31:0] x, input logic [2:0] rm,
                        input logic [TAGW-1:0] tag, input logic rr, input logic fl,
                        input logic use_c, input logic [31:0] cf, input logic ci);
        logic  exp_ready;
        item_t it;
        @(posedge clk);
        #1;
        req_valid = v; req_int = x; req_rm = rm; req_tag = tag;
        rsp_ready = rr; flush = fl;
        @(negedge clk);
        exp_ready = !fl && (exp_q.size() < DEPTH);
        chk("req_ready", req_ready, exp_ready);
        if (fl) exp_q.delete();
        else if (v && exp_ready) begin
            it.f        = use_c ? cf : ref_i2f(x, rm);
            it.tag      = tag;
            it.inex     = use_c ? ci : ref_inexact(x);
            it.acc_edge = edges + 1;
            exp_q.push_back(it);
        end
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'h0, 3'd0, '0, rr, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rnd_req(input logic rr, input logic fl);
        logic [31:0] x;
        case ($urandom_range(0, 3))
            0:       x = $urandom_range(0, 1000);
            1:       x = $urandom;
            2:       x = (32'h1 << $urandom_range(0, 31)) + $urandom_range(0, 255);
            default: x = $urandom_range(0, 1) ? 32'h80000000 : 32'hFFFFFFFF;
        endcase
        if ($urandom_range(0, 3) == 0) x = ~x + 32'h1;
        step(1'($urandom_range(0, 1)), x, 3'($urandom_range(0, 4)), TAGW'($urandom),
             rr, fl, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: checks rsp_valid timing every cycle and pops on each handshake.
    initial begin
        logic exp_v;
        item_t h;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !flush) begin
                exp_v = (exp_q.size() > 0) && (edges >= exp_q[0].acc_edge + 1);
                chk("rsp_valid", rsp_valid, exp_v);
                if (exp_v && rsp_valid && rsp_ready) begin
                    h = exp_q.pop_front();
                    chk("rsp_f", rsp_f, h.f);
                    chk("rsp_tag", rsp_tag, h.tag);
                    chk("rsp_inexact", rsp_inexact, h.inex);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_f", rsp_f, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_inexact", rsp_inexact, 0);

        step(1'b1, 32'd16777217, 3'd0, 4'd3, 1'b1, 1'b0, 1'b1, 32'h4B800000, 1'b1);
        repeat (3) idle(1'b1);
        step(1'b1, 32'd16777226, 3'd0, 4'd4, 1'b1, 1'b0, 1'b1, 32'h4B800005, 1'b0);
        step(1'b1, 32'd0,        3'd0, 4'd5, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0);
        step(1'b1, 32'hFFFFFFFF, 3'd0, 4'd6, 1'b1, 1'b0, 1'b1, 32'hBF800000, 1'b0);
        step(1'b1, 32'h80000000, 3'd1, 4'd7, 1'b1, 1'b0, 1'b1, 32'hCF000000, 1'b0);
        step(1'b1, 32'h7FFFFFFF, 3'd1, 4'd8, 1'b1, 1'b0, 1'b1, 32'h4EFFFFFF, 1'b1);
        repeat (3) idle(1'b1);

        for (int i = 0; i < 6; i++) rnd_req(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);

        for (int i = 0; i < 12; i++)
            step(1'b1, $urandom, 3'($urandom_range(0, 4)), TAGW'(i), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) idle(1'b1);

        for (int i = 0; i < 4; i++)
            step(1'b1, $urandom, 3'd0, TAGW'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'd99, 3'd0, 4'd9, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'd100, 3'd0, 4'd10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) idle(1'b1);

        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, 3'd0, TAGW'(i), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) idle(1'b1);

        for (int i = 0; i < 400; i++)
            rnd_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));

        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            idle(1'b1);
        end
        chk("drain_empty", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
